// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one down-counting wait timer among Requesters clients.
// Rev 1.0
`default_nettype none

module timer_arbiter #(
  parameter int Requesters = 4,
  parameter int Width      = 32
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [Requesters-1:0]         req,
  input  logic [Requesters*Width-1:0]   count,
  output logic [Requesters-1:0]         grant,
  output logic [Requesters-1:0]         done,
  output logic                          busy
);

  localparam int IdxW = (Requesters > 1) ? $clog2(Requesters) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [Width-1:0]      timer;
  logic [IdxW-1:0]       ptr;
  logic [IdxW-1:0]       sel;
  logic [IdxW-1:0]       cand;
  logic [IdxW-1:0]       owner_next;
  logic                  found;
  logic [Requesters-1:0] grant_next;
  logic [Requesters-1:0] done_next;
  logic [Width-1:0]      counts [Requesters];

  generate
    for (genvar i = 0; i < Requesters; i++) begin : g_unpack
      assign counts[i] = count[i*Width +: Width];
    end
  endgenerate

  // ptr always holds the most recent owner, so the search starts just past it.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int k = 1; k <= Requesters; k++) begin
      cand = IdxW'((int'(ptr) + k) % Requesters);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      timer <= '0;
      ptr   <= IdxW'(Requesters - 1);
      grant <= '0;
      done  <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      done  <= done_next;
      if (state == IDLE && found) begin
        timer <= counts[sel];
        ptr   <= sel;
      end else if (state == RUN && state_next == RUN) begin
        timer <= timer - Width'(1);
      end
    end
  end

  // A latched count of 0 leaves RUN after one cycle, same as a count of 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = RUN;
      RUN: begin
        if (!req[ptr])                state_next = IDLE;
        else if (timer <= Width'(1))  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next = '0;
    done_next  = '0;
    owner_next = (state == IDLE) ? sel : ptr;
    if (state_next == RUN)  grant_next = Requesters'(1) << owner_next;
    if (state_next == DONE) done_next  = Requesters'(1) << ptr;
  end

  assign busy = (|grant) | (|done);

endmodule

`default_nettype wire

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: table-driven cycle vectors plus reactive round-robin and fairness sequences.
`default_nettype none

module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           res;
  logic [N-1:0]   req;
  logic [N*W-1:0] count;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  int errors = 0;
  int checks = 0;

  timer_arbiter #(.Requesters(N), .Width(W)) dut (
    .clk   (clk),
    .res   (res),
    .req   (req),
    .count (count),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] c;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] c,
                              input logic [3:0] g, input logic [3:0] d, input logic b);
    vec_t v;
    v.rst = r; v.rq = rq; v.c = c; v.g = g; v.d = d; v.b = b;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] c);
    @(negedge clk);
    res   = r;
    req   = rq;
    count = {N{c}};
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [3:0] d, input logic b);
    checks++;
    if ({grant, done, busy} !== {g, d, b}) begin
      errors++;
      $display("FAIL %s: got grant=%b done=%b busy=%b, want grant=%b done=%b busy=%b",
               name, grant, done, busy, g, d, b);
    end
  endtask

  initial begin
    logic [3:0] served;
    logic [3:0] drop;
    logic [3:0] eg;
    logic [3:0] ed;
    int         k;
    int         ph;

    res = 1'b1; req = '0; count = '0;

    // Reset state
    vecs[0]  = mk(1, 4'b0000, 0,  4'b0000, 4'b0000, 0);
    // Single job: client 2, count 3
    vecs[1]  = mk(0, 4'b0100, 3,  4'b0100, 4'b0000, 1);
    vecs[2]  = mk(0, 4'b0100, 3,  4'b0100, 4'b0000, 1);
    vecs[3]  = mk(0, 4'b0100, 3,  4'b0100, 4'b0000, 1);
    vecs[4]  = mk(0, 4'b0100, 3,  4'b0000, 4'b0100, 1);
    vecs[5]  = mk(0, 4'b0000, 3,  4'b0000, 4'b0000, 0);
    vecs[6]  = mk(0, 4'b0000, 3,  4'b0000, 4'b0000, 0);
    // Zero count on client 0, then count 1 for comparison
    vecs[7]  = mk(0, 4'b0001, 0,  4'b0001, 4'b0000, 1);
    vecs[8]  = mk(0, 4'b0001, 0,  4'b0000, 4'b0001, 1);
    vecs[9]  = mk(0, 4'b0000, 0,  4'b0000, 4'b0000, 0);
    vecs[10] = mk(0, 4'b0001, 1,  4'b0001, 4'b0000, 1);
    vecs[11] = mk(0, 4'b0001, 1,  4'b0000, 4'b0001, 1);
    vecs[12] = mk(0, 4'b0000, 1,  4'b0000, 4'b0000, 0);
    // Abort: client 1, count 10, dropped after 4 grant cycles
    vecs[13] = mk(0, 4'b0010, 10, 4'b0010, 4'b0000, 1);
    vecs[14] = mk(0, 4'b0010, 10, 4'b0010, 4'b0000, 1);
    vecs[15] = mk(0, 4'b0010, 10, 4'b0010, 4'b0000, 1);
    vecs[16] = mk(0, 4'b0010, 10, 4'b0010, 4'b0000, 1);
    vecs[17] = mk(0, 4'b0000, 10, 4'b0000, 4'b0000, 0);
    // Client 2 served normally after the abort
    vecs[18] = mk(0, 4'b0100, 2,  4'b0100, 4'b0000, 1);
    vecs[19] = mk(0, 4'b0100, 2,  4'b0100, 4'b0000, 1);
    vecs[20] = mk(0, 4'b0100, 2,  4'b0000, 4'b0100, 1);
    vecs[21] = mk(0, 4'b0000, 2,  4'b0000, 4'b0000, 0);
    // Reset in the middle of client 3's 8-cycle wait
    vecs[22] = mk(0, 4'b1000, 8,  4'b1000, 4'b0000, 1);
    vecs[23] = mk(0, 4'b1000, 8,  4'b1000, 4'b0000, 1);
    vecs[24] = mk(1, 4'b1000, 8,  4'b0000, 4'b0000, 0);
    // After reset client 0 wins over client 3
    vecs[25] = mk(0, 4'b1001, 2,  4'b0001, 4'b0000, 1);
    vecs[26] = mk(0, 4'b1001, 2,  4'b0001, 4'b0000, 1);
    vecs[27] = mk(0, 4'b1001, 2,  4'b0000, 4'b0001, 1);
    vecs[28] = mk(0, 4'b1000, 2,  4'b0000, 4'b0000, 0);
    vecs[29] = mk(0, 4'b1000, 2,  4'b1000, 4'b0000, 1);
    vecs[30] = mk(1, 4'b0000, 2,  4'b0000, 4'b0000, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].rq, vecs[i].c);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].d, vecs[i].b);
    end

    // Round robin: all four request with count 2, each drops req once its done is seen.
    step(1, 4'b0000, 2);
    check("rr_reset", 4'b0000, 4'b0000, 0);
    served = 4'b0000;
    for (int n = 1; n <= 16; n++) begin
      step(0, 4'b1111 & ~served, 2);
      k  = (n - 1) / 4;
      ph = (n - 1) % 4;
      eg = (ph < 2)  ? (4'b0001 << k) : 4'b0000;
      ed = (ph == 2) ? (4'b0001 << k) : 4'b0000;
      check($sformatf("rr_cycle%0d", n), eg, ed, (ph != 3));
      served = served | done;
    end

    // Fairness: clients 1 and 3 re-request right after each done, count 1.
    step(1, 4'b0000, 1);
    check("fair_reset", 4'b0000, 4'b0000, 0);
    drop = 4'b0000;
    for (int n = 1; n <= 12; n++) begin
      step(0, 4'b1010 & ~drop, 1);
      k  = (n - 1) / 3;
      ph = (n - 1) % 3;
      eg = (ph == 0) ? ((k % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      ed = (ph == 1) ? ((k % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      check($sformatf("fair_cycle%0d", n), eg, ed, (ph != 2));
      drop = done & 4'b1010;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
